// File: rtl/hs32_sram_arb.sv
// -----------------------------------------------------------------------------
// hs32_sram_arb
// Single-port access arbiter for port 0 of a sky130 1rw1r SRAM macro, shared
// between the hs32 CPU memory port and the management-SoC Wishbone slave.
// The CPU path is fully pipelined: one access per cycle, and reads return
// in order 2 cycles after grant. The Wishbone path is single-outstanding.
// A Wishbone hit that keeps losing to the CPU is force-granted after
// WB_MAXWAIT lost cycles.
//
// Ports
//   wb_clk_i, wb_rst_ni        clock (also clocks the macro), sync active-low reset
//   cpu_req_i/we/sel/adr/dat   CPU request; cpu_gnt_o is combinational accept
//   cpu_rvalid_o, cpu_dat_o    CPU read return, 2 cycles after grant
//   wbs_*_i                    Wishbone classic slave inputs (byte address)
//   wbs_ack_o, wbs_dat_o       one-cycle ack, read data valid with ack
//   ram_csb_o..ram_din_o       registered macro port-0 controls (active low csb/web)
//   ram_dout_i                 macro read data, valid the cycle after capture
// -----------------------------------------------------------------------------
module hs32_sram_arb #(
   parameter int unsigned AW         = 8,
   parameter logic [31:0] WB_BASE    = 32'h3000_0000,
   parameter logic [31:0] WB_MASK    = 32'hFFFF_FC00,
   parameter int unsigned WB_MAXWAIT = 4
) (
   input  logic          wb_clk_i,
   input  logic          wb_rst_ni,
   input  logic          cpu_req_i,
   input  logic          cpu_we_i,
   input  logic [3:0]    cpu_sel_i,
   input  logic [AW-1:0] cpu_adr_i,
   input  logic [31:0]   cpu_dat_i,
   output logic          cpu_gnt_o,
   output logic          cpu_rvalid_o,
   output logic [31:0]   cpu_dat_o,
   input  logic          wbs_cyc_i,
   input  logic          wbs_stb_i,
   input  logic          wbs_we_i,
   input  logic [3:0]    wbs_sel_i,
   input  logic [31:0]   wbs_adr_i,
   input  logic [31:0]   wbs_dat_i,
   output logic          wbs_ack_o,
   output logic [31:0]   wbs_dat_o,
   output logic          ram_csb_o,
   output logic          ram_web_o,
   output logic [3:0]    ram_wmask_o,
   output logic [AW-1:0] ram_addr_o,
   output logic [31:0]   ram_din_o,
   input  logic [31:0]   ram_dout_i
);

   localparam int unsigned   CW       = (WB_MAXWAIT < 1) ? 1 : $clog2(WB_MAXWAIT + 1);
   localparam logic [CW-1:0] WAIT_MAX = CW'(WB_MAXWAIT);
   localparam logic [CW-1:0] WAIT_ONE = CW'(1);

   logic [CW-1:0] wait_cnt_r;
   logic [CW-1:0] wait_cnt_nxt_s;
   logic          wb_s1_r;        // WB access has its SRAM pins driven this cycle
   logic          wb_s2_r;        // WB access is in its data-return cycle
   logic          wb_s2_live_r;   // that access still had cyc high in its pin cycle
   logic          cpu_rd_s1_r;    // CPU read has its SRAM pins driven this cycle
   logic          cpu_rvalid_r;
   logic          wb_busy_s;
   logic          wb_hit_s;
   logic          wb_force_s;
   logic          cpu_win_s;
   logic          wb_win_s;
   logic          gnt_s;
   logic          sel_we_s;
   logic [3:0]    sel_sel_s;
   logic [AW-1:0] sel_adr_s;
   logic [31:0]   sel_dat_s;

   // Busy covers the pin cycle and the ack cycle of the outstanding WB access.
   assign wb_busy_s = wb_s1_r | wb_s2_r;

   // Arbitration: a starved WB hit preempts the CPU, otherwise the CPU wins.
   always_comb begin
      wb_hit_s   = wbs_cyc_i & wbs_stb_i & ((wbs_adr_i & WB_MASK) == WB_BASE) & ~wb_busy_s;
      wb_force_s = wb_hit_s & (wait_cnt_r == WAIT_MAX);
      cpu_win_s  = cpu_req_i & ~wb_force_s;
      wb_win_s   = wb_hit_s & ~cpu_win_s;
      gnt_s      = cpu_win_s | wb_win_s;
   end

   // Request mux feeding the SRAM pin registers.
   always_comb begin
      sel_we_s  = cpu_we_i;
      sel_sel_s = cpu_sel_i;
      sel_adr_s = cpu_adr_i;
      sel_dat_s = cpu_dat_i;
      if (wb_win_s) begin
         sel_we_s  = wbs_we_i;
         sel_sel_s = wbs_sel_i;
         sel_adr_s = wbs_adr_i[AW+1:2];
         sel_dat_s = wbs_dat_i;
      end else begin
         sel_we_s  = cpu_we_i;
         sel_sel_s = cpu_sel_i;
         sel_adr_s = cpu_adr_i;
         sel_dat_s = cpu_dat_i;
      end
   end

   // Starvation counter: counts lost cycles of a pending hit, saturating.
   always_comb begin
      wait_cnt_nxt_s = wait_cnt_r;
      if (!wb_hit_s) begin
         wait_cnt_nxt_s = '0;
      end else if (wb_win_s) begin
         wait_cnt_nxt_s = '0;
      end else if (wait_cnt_r != WAIT_MAX) begin
         wait_cnt_nxt_s = wait_cnt_r + WAIT_ONE;
      end else begin
         wait_cnt_nxt_s = wait_cnt_r;
      end
   end

   // Pipeline state, SRAM pin registers and response flags.
   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_ni) begin
         wait_cnt_r   <= '0;
         wb_s1_r      <= 1'b0;
         wb_s2_r      <= 1'b0;
         wb_s2_live_r <= 1'b0;
         cpu_rd_s1_r  <= 1'b0;
         cpu_rvalid_r <= 1'b0;
         ram_csb_o    <= 1'b1;
         ram_web_o    <= 1'b1;
         ram_wmask_o  <= 4'h0;
         ram_addr_o   <= '0;
         ram_din_o    <= 32'h0;
      end else begin
         wait_cnt_r   <= wait_cnt_nxt_s;
         wb_s1_r      <= wb_win_s;
         wb_s2_r      <= wb_s1_r;
         // Dropping cyc in the pin cycle aborts the ack; the SRAM access still completes.
         wb_s2_live_r <= wb_s1_r & wbs_cyc_i;
         cpu_rd_s1_r  <= cpu_win_s & ~cpu_we_i;
         cpu_rvalid_r <= cpu_rd_s1_r;
         if (gnt_s) begin
            ram_csb_o   <= 1'b0;
            ram_web_o   <= ~sel_we_s;
            ram_wmask_o <= sel_sel_s;
            ram_addr_o  <= sel_adr_s;
            ram_din_o   <= sel_dat_s;
         end else begin
            // Idle cycle: deselect, leave the remaining pins untouched.
            ram_csb_o   <= 1'b1;
         end
      end
   end

   assign cpu_gnt_o    = cpu_win_s;
   assign cpu_rvalid_o = cpu_rvalid_r;
   assign cpu_dat_o    = ram_dout_i;
   // Dropping cyc in the ack cycle also suppresses the ack.
   assign wbs_ack_o    = wb_s2_live_r & wbs_cyc_i;
   assign wbs_dat_o    = ram_dout_i;

endmodule

// File: tb/tb_hs32_sram_arb.sv
// -----------------------------------------------------------------------------
// tb_hs32_sram_arb
// Directed bench for hs32_sram_arb with a behavioural SRAM macro. Stimulus
// pushes hand-computed read data and the cycle it must appear into queues;
// a negedge monitor pops and compares on cpu_rvalid_o / wbs_ack_o.
// -----------------------------------------------------------------------------
module tb_hs32_sram_arb;

   typedef struct {
      logic [31:0] data;
      int          cyc;
      bit          rd;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
   logic [3:0]  cpu_sel;
   logic [7:0]  cpu_adr;
   logic [31:0] cpu_wdat, cpu_rdat;
   logic        wb_cyc, wb_stb, wb_we, wb_ack;
   logic [3:0]  wb_sel;
   logic [31:0] wb_adr, wb_wdat, wb_rdat;
   logic        ram_csb, ram_web;
   logic [3:0]  ram_wmask;
   logic [7:0]  ram_addr;
   logic [31:0] ram_din, ram_dout;

   logic [31:0] mem [0:255];
   exp_t        cpu_q[$];
   exp_t        wb_q[$];
   int          cyc_cnt = 0;
   int          checks  = 0;
   int          errors  = 0;

   hs32_sram_arb dut (
      .wb_clk_i     (clk),
      .wb_rst_ni    (rst_n),
      .cpu_req_i    (cpu_req),
      .cpu_we_i     (cpu_we),
      .cpu_sel_i    (cpu_sel),
      .cpu_adr_i    (cpu_adr),
      .cpu_dat_i    (cpu_wdat),
      .cpu_gnt_o    (cpu_gnt),
      .cpu_rvalid_o (cpu_rvalid),
      .cpu_dat_o    (cpu_rdat),
      .wbs_cyc_i    (wb_cyc),
      .wbs_stb_i    (wb_stb),
      .wbs_we_i     (wb_we),
      .wbs_sel_i    (wb_sel),
      .wbs_adr_i    (wb_adr),
      .wbs_dat_i    (wb_wdat),
      .wbs_ack_o    (wb_ack),
      .wbs_dat_o    (wb_rdat),
      .ram_csb_o    (ram_csb),
      .ram_web_o    (ram_web),
      .ram_wmask_o  (ram_wmask),
      .ram_addr_o   (ram_addr),
      .ram_din_o    (ram_din),
      .ram_dout_i   (ram_dout)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   // Behavioural macro port 0: captures at the edge, read data follows the edge.
   always @(posedge clk) begin
      if (ram_csb === 1'b0) begin
         if (ram_web === 1'b0) begin
            for (int b = 0; b < 4; b++)
               if (ram_wmask[b]) mem[ram_addr][8*b +: 8] <= ram_din[8*b +: 8];
         end else begin
            ram_dout <= mem[ram_addr];
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc_cnt);
      end
   endtask

   // Scoreboard monitor.
   always @(negedge clk) begin
      exp_t e;
      if (cpu_rvalid === 1'b1) begin
         if (cpu_q.size() == 0) begin
            chk("cpu_rvalid_unexpected", 32'd1, 32'd0);
         end else begin
            e = cpu_q.pop_front();
            chk("cpu_rvalid_cycle", cyc_cnt, e.cyc);
            chk("cpu_rdata", cpu_rdat, e.data);
         end
      end
      if (wb_ack === 1'b1) begin
         if (wb_q.size() == 0) begin
            chk("wb_ack_unexpected", 32'd1, 32'd0);
         end else begin
            e = wb_q.pop_front();
            chk("wb_ack_cycle", cyc_cnt, e.cyc);
            if (e.rd) chk("wb_rdata", wb_rdat, e.data);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cpu_idle();
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_sel = 4'h0; cpu_adr = 8'h00; cpu_wdat = 32'h0;
   endtask

   task automatic wb_idle();
      wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0; wb_sel = 4'h0; wb_adr = 32'h0; wb_wdat = 32'h0;
   endtask

   // Single CPU read with no competition; granted in its first cycle.
   task automatic cpu_read(input logic [7:0] adr, input logic [31:0] exp_data);
      exp_t e;
      tick();
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_sel = 4'hF; cpu_adr = adr;
      @(negedge clk);
      chk("cpu_read_gnt", {31'd0, cpu_gnt}, 32'd1);
      e.data = exp_data; e.cyc = cyc_cnt + 2; e.rd = 1'b1;
      cpu_q.push_back(e);
      tick();
      cpu_idle();
      repeat (3) tick();
   endtask

   // WB access expected to be granted after 'wait_n' lost cycles; holds stb until ack.
   task automatic wb_access(input logic [31:0] adr, input logic we, input logic [3:0] sel,
                            input logic [31:0] dat, input logic [31:0] exp_data, input int wait_n);
      exp_t e;
      bit   seen;
      tick();
      wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_sel = sel; wb_adr = adr; wb_wdat = dat;
      e.data = exp_data; e.cyc = cyc_cnt + wait_n + 2; e.rd = ~we;
      wb_q.push_back(e);
      seen = 1'b0;
      for (int i = 0; i < 16 && !seen; i++) begin
         @(negedge clk);
         if (wb_ack === 1'b1) seen = 1'b1;
      end
      if (!seen) chk("wb_ack_timeout", 32'd0, 32'd1);
      tick();
      wb_idle();
      repeat (2) tick();
   endtask

   initial begin
      exp_t e;
      int   s;
      cpu_idle();
      wb_idle();
      // 1. Reset held with a CPU request pending.
      rst_n   = 1'b0;
      cpu_req = 1'b1;
      repeat (3) tick();
      @(negedge clk);
      chk("rst_csb",    {31'd0, ram_csb},    32'd1);
      chk("rst_web",    {31'd0, ram_web},    32'd1);
      chk("rst_wmask",  {28'd0, ram_wmask},  32'd0);
      chk("rst_addr",   {24'd0, ram_addr},   32'd0);
      chk("rst_din",    ram_din,             32'd0);
      chk("rst_rvalid", {31'd0, cpu_rvalid}, 32'd0);
      chk("rst_ack",    {31'd0, wb_ack},     32'd0);
      tick();
      cpu_idle();
      rst_n = 1'b1;
      repeat (2) tick();

      // 2. CPU write @5 then read @5 back-to-back.
      tick();
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_sel = 4'hF; cpu_adr = 8'd5; cpu_wdat = 32'hDEAD_BEEF;
      @(negedge clk);
      chk("cpu_wr_gnt", {31'd0, cpu_gnt}, 32'd1);
      tick();
      cpu_we = 1'b0; cpu_wdat = 32'h0;
      @(negedge clk);
      chk("cpu_rd_gnt", {31'd0, cpu_gnt}, 32'd1);
      e.data = 32'hDEAD_BEEF; e.cyc = cyc_cnt + 2; e.rd = 1'b1;
      cpu_q.push_back(e);
      chk("wr_pin_csb",   {31'd0, ram_csb},   32'd0);
      chk("wr_pin_web",   {31'd0, ram_web},   32'd0);
      chk("wr_pin_wmask", {28'd0, ram_wmask}, 32'hF);
      chk("wr_pin_addr",  {24'd0, ram_addr},  32'd5);
      chk("wr_pin_din",   ram_din,            32'hDEAD_BEEF);
      tick();
      cpu_idle();
      @(negedge clk);
      chk("rd_pin_web", {31'd0, ram_web}, 32'd1);
      repeat (3) tick();

      // 3. WB byte write into byte 1 of word 5, then CPU read-back.
      wb_access(32'h3000_0014, 1'b1, 4'b0010, 32'h0000_AB00, 32'h0, 0);
      cpu_read(8'd5, 32'hDEAD_ABEF);

      // 4. Starvation: CPU reads every cycle, WB read pending.
      tick();
      s = cyc_cnt;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_sel = 4'hF; cpu_adr = 8'd5;
      wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_sel = 4'hF; wb_adr = 32'h3000_0014;
      e.data = 32'hDEAD_ABEF; e.cyc = s + 6; e.rd = 1'b1;
      wb_q.push_back(e);
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         chk($sformatf("starve_gnt_k%0d", k), {31'd0, cpu_gnt}, (k == 4) ? 32'd0 : 32'd1);
         if (cpu_gnt === 1'b1) begin
            e.data = 32'hDEAD_ABEF; e.cyc = cyc_cnt + 2; e.rd = 1'b1;
            cpu_q.push_back(e);
         end
         tick();
         if (k == 6) wb_idle();
      end
      cpu_idle();
      repeat (4) tick();

      // 5a. Miss: outside the window, never acked or issued.
      tick();
      wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_sel = 4'hF; wb_adr = 32'h3000_0400;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         chk("miss_ack", {31'd0, wb_ack}, 32'd0);
         if (k > 0) chk("miss_csb", {31'd0, ram_csb}, 32'd1);
         tick();
      end
      wb_idle();
      tick();

      // 5b. Abort: write word 6, cyc dropped in the pin cycle.
      wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1; wb_sel = 4'hF; wb_adr = 32'h3000_0018;
      wb_wdat = 32'h1234_5678;
      @(negedge clk);
      chk("abort_ack_n", {31'd0, wb_ack}, 32'd0);
      tick();
      wb_idle();
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("abort_ack_later", {31'd0, wb_ack}, 32'd0);
         tick();
      end
      cpu_read(8'd6, 32'h1234_5678);
      wb_access(32'h3000_0018, 1'b0, 4'hF, 32'h0, 32'h1234_5678, 0);

      // 6. Reset asserted in the pin cycle of a CPU read.
      tick();
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_sel = 4'hF; cpu_adr = 8'd5;
      @(negedge clk);
      chk("midrst_gnt", {31'd0, cpu_gnt}, 32'd1);
      tick();
      cpu_idle();
      rst_n = 1'b0;
      @(negedge clk);
      chk("midrst_pin_csb", {31'd0, ram_csb}, 32'd0);
      tick();
      rst_n = 1'b1;
      @(negedge clk);
      chk("midrst_rvalid", {31'd0, cpu_rvalid}, 32'd0);
      chk("midrst_csb",    {31'd0, ram_csb},    32'd1);
      repeat (4) tick();

      chk("cpu_q_drained", cpu_q.size(), 32'd0);
      chk("wb_q_drained",  wb_q.size(),  32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
